// File: rtl/pe_accumulator_buffer_core_pkg.sv
// Shared PE accumulator buffer types: default geometry, crossbar input packet, PPU output packet
// and the drain FSM state encoding.
package pe_accumulator_buffer_core_pkg;

  localparam int unsigned DefNumBanks = 4;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefAccW     = 24;
  localparam int unsigned DefDepth    = 64;
  localparam int unsigned DefAw       = $clog2(DefDepth);

  typedef struct packed {
    logic                       valid;
    logic [DefAw-1:0]           addr;
    logic signed [DefDataW-1:0] data;
  } xbar_bank_t;

  typedef xbar_bank_t [DefNumBanks-1:0] crossbar_buffer_in_PACKET;

  typedef struct packed {
    logic                                  valid;
    logic                                  last;
    logic [DefAw-1:0]                      addr;
    logic [DefNumBanks-1:0][DefAccW-1:0]   data;
  } Buffer_PPU_PACKET;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } drain_state_e;

endpackage

// File: rtl/pe_accumulator_buffer_core_if.sv
// Bus between the crossbar/drain controller (master) and the accumulator buffer core (slave).
interface pe_accumulator_buffer_core_if;
  import pe_accumulator_buffer_core_pkg::*;

  logic [DefAw:0]           Conv_size_output_Boundary;
  logic                     drain_Accumulator_buffer_en;
  crossbar_buffer_in_PACKET crossbar_buffer_data_in;
  Buffer_PPU_PACKET         buffer_PPU_data;

  modport master (
    output Conv_size_output_Boundary,
    output drain_Accumulator_buffer_en,
    output crossbar_buffer_data_in,
    input  buffer_PPU_data
  );

  modport slave (
    input  Conv_size_output_Boundary,
    input  drain_Accumulator_buffer_en,
    input  crossbar_buffer_data_in,
    output buffer_PPU_data
  );

endinterface

// File: rtl/pe_accumulator_buffer_core_acc_bank.sv
// One accumulator bank: read-modify-write accumulate port plus a read-and-clear drain port.
// Define PE_ACC_SATURATE_EN to clamp the add instead of wrapping.
module pe_accumulator_buffer_core_acc_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     acc_en,
  input  logic [AW-1:0]            acc_addr,
  input  logic signed [DATA_W-1:0] acc_data,
  input  logic                     clr_en,
  input  logic [AW-1:0]            clr_addr,
  output logic [ACC_W-1:0]         rd_data
);

  logic [ACC_W-1:0] mem_q [DEPTH];
  logic [ACC_W-1:0] acc_cur;
  logic [ACC_W-1:0] acc_sum;

  assign acc_cur = mem_q[acc_addr];
  assign rd_data = mem_q[clr_addr];

`ifdef PE_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SatMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SatMin = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_wide;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign sum_wide = $signed({acc_cur[ACC_W-1], acc_cur}) + (ACC_W+1)'(acc_data);

  always_comb begin
    acc_sum = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_sum = sum_wide[ACC_W] ? SatMin : SatMax;
    end
  end
`else
  assign acc_sum = acc_cur + ACC_W'(acc_data);
`endif

  // Drain clear and accumulate are never requested together; clear wins defensively.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else if (acc_en) begin
      mem_q[acc_addr] <= acc_sum;
    end
  end

endmodule

// File: rtl/pe_accumulator_buffer_core.sv
// PE accumulator buffer: NUM_BANKS independent accumulator banks fed by the crossbar, drained
// address by address to the PPU. Optional clamping add: PE_ACC_SATURATE_EN.
module pe_accumulator_buffer_core
  import pe_accumulator_buffer_core_pkg::*;
#(
  parameter int unsigned NUM_BANKS = DefNumBanks,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned DEPTH     = DefDepth,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input logic                          clk,
  input logic                          rst,
  pe_accumulator_buffer_core_if.slave  bus
);

  drain_state_e     state_q, state_d;
  logic             armed_q, armed_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW:0]      bound_q, bound_d;
  Buffer_PPU_PACKET out_q, out_d;

  logic [AW:0]                      bound_clamped;
  logic                             is_last;
  logic                             drain_en;
  logic [NUM_BANKS-1:0]             acc_en;
  logic                             clr_en;
  logic [NUM_BANKS-1:0][ACC_W-1:0]  rd_data;

  assign drain_en      = bus.drain_Accumulator_buffer_en;
  assign bound_clamped = (bus.Conv_size_output_Boundary > (AW+1)'(DEPTH)) ?
                         (AW+1)'(DEPTH) : bus.Conv_size_output_Boundary;
  assign is_last       = ({1'b0, cnt_q} == (bound_q - 1'b1));

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    pe_accumulator_buffer_core_acc_bank #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .acc_en   (acc_en[b]),
      .acc_addr (bus.crossbar_buffer_data_in[b].addr),
      .acc_data (bus.crossbar_buffer_data_in[b].data),
      .clr_en   (clr_en),
      .clr_addr (cnt_q),
      .rd_data  (rd_data[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      bound_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      bound_q <= bound_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    bound_d = bound_q;
    // Re-arm only after drain_en has been seen low, so a held request fires once.
    if (!drain_en) begin
      armed_d = 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (drain_en && armed_q && (bus.Conv_size_output_Boundary != '0)) begin
          state_d = StDrain;
          cnt_d   = '0;
          bound_d = bound_clamped;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (is_last) begin
          state_d = StIdle;
          armed_d = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    out_d       = out_q;
    out_d.valid = 1'b0;
    clr_en      = 1'b0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      acc_en[b] = (state_q == StIdle) && bus.crossbar_buffer_data_in[b].valid;
    end
    if (state_q == StDrain) begin
      clr_en      = 1'b1;
      out_d.valid = 1'b1;
      out_d.last  = is_last;
      out_d.addr  = cnt_q;
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        out_d.data[b] = rd_data[b];
      end
    end
  end

  assign bus.buffer_PPU_data = out_q;

endmodule

// File: tb/tb_pe_accumulator_buffer_core.sv
// Directed bench for pe_accumulator_buffer_core with a hand-filled expected-entry table.
module tb_pe_accumulator_buffer_core;
  import pe_accumulator_buffer_core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_accumulator_buffer_core_if bus ();

  pe_accumulator_buffer_core #(
    .NUM_BANKS (DefNumBanks),
    .DATA_W    (DefDataW),
    .ACC_W     (DefAccW),
    .DEPTH     (DefDepth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DefAccW-1:0] exp_mem [DefNumBanks][DefDepth];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_xbar;
    bus.crossbar_buffer_data_in = '0;
  endtask

  task automatic drive(input int b, input int addr, input int data);
    bus.crossbar_buffer_data_in[b].valid = 1'b1;
    bus.crossbar_buffer_data_in[b].addr  = addr[DefAw-1:0];
    bus.crossbar_buffer_data_in[b].data  = data[DefDataW-1:0];
  endtask

  // Starts a drain, checks every output beat against exp_mem, then the idle beat after it.
  task automatic run_drain(input string tag, input int bound, input int n_out,
                           input bit hold_en, input bit inject);
    bus.Conv_size_output_Boundary   = bound[DefAw:0];
    bus.drain_Accumulator_buffer_en = 1'b1;
    tick;
    check({tag, " pre_valid"}, 64'(bus.buffer_PPU_data.valid), 64'd0);
    if (!hold_en) bus.drain_Accumulator_buffer_en = 1'b0;
    bus.Conv_size_output_Boundary = 7'd1;
    if (inject) drive(0, 7, 9);
    for (int i = 0; i < n_out; i++) begin
      tick;
      check({tag, " valid"}, 64'(bus.buffer_PPU_data.valid), 64'd1);
      check({tag, " addr"}, 64'(bus.buffer_PPU_data.addr), 64'(i));
      check({tag, " last"}, 64'(bus.buffer_PPU_data.last), 64'(i == n_out - 1));
      for (int b = 0; b < int'(DefNumBanks); b++) begin
        check({tag, " data"}, 64'(bus.buffer_PPU_data.data[b]), 64'(exp_mem[b][i]));
        exp_mem[b][i] = '0;
      end
    end
    clear_xbar;
    tick;
    check({tag, " post_valid"}, 64'(bus.buffer_PPU_data.valid), 64'd0);
    check({tag, " post_last"}, 64'(bus.buffer_PPU_data.last), 64'd1);
    check({tag, " post_addr"}, 64'(bus.buffer_PPU_data.addr), 64'(n_out - 1));
  endtask

  initial begin
    for (int b = 0; b < int'(DefNumBanks); b++) begin
      for (int a = 0; a < int'(DefDepth); a++) exp_mem[b][a] = '0;
    end
    rst = 1'b1;
    bus.drain_Accumulator_buffer_en = 1'b0;
    bus.Conv_size_output_Boundary   = '0;
    clear_xbar;
    tick;
    tick;
    check("rst valid", 64'(bus.buffer_PPU_data.valid), 64'd0);
    check("rst last", 64'(bus.buffer_PPU_data.last), 64'd0);
    check("rst addr", 64'(bus.buffer_PPU_data.addr), 64'd0);
    for (int b = 0; b < int'(DefNumBanks); b++) begin
      check("rst data", 64'(bus.buffer_PPU_data.data[b]), 64'd0);
    end
    rst = 1'b0;
    tick;

    // +5 then -2 into bank0 addr3
    drive(0, 3, 5);
    tick;
    drive(0, 3, -2);
    tick;
    clear_xbar;
    exp_mem[0][3] = 24'd3;
    run_drain("s1", 4, 4, 1'b0, 1'b0);

    // back-to-back accumulation, two banks at once
    drive(1, 0, 100);
    drive(2, 5, -7);
    tick;
    tick;
    tick;
    clear_xbar;
    exp_mem[1][0] = 24'd300;
    exp_mem[2][5] = 24'hFFFFEB;
    run_drain("s2", 6, 6, 1'b0, 1'b0);

    // held drain_en: one drain only, then re-trigger after a low
    run_drain("s3", 2, 2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick;
      check("s3 no_retrigger", 64'(bus.buffer_PPU_data.valid), 64'd0);
    end
    bus.drain_Accumulator_buffer_en = 1'b0;
    tick;
    run_drain("s3b", 2, 2, 1'b0, 1'b0);

    // crossbar traffic during a drain is dropped; second drain is all zero
    run_drain("s4a", 8, 8, 1'b0, 1'b1);
    run_drain("s4b", 8, 8, 1'b0, 1'b0);

    // 256*32767 + 248 = 8388600, then +100 crosses the positive limit
    for (int i = 0; i < 256; i++) begin
      drive(3, 2, 32767);
      tick;
    end
    drive(3, 2, 248);
    tick;
    drive(3, 2, 100);
    tick;
    clear_xbar;
`ifdef PE_ACC_SATURATE_EN
    exp_mem[3][2] = 24'h7FFFFF;
`else
    exp_mem[3][2] = 24'h80005C;
`endif
    run_drain("s5", 3, 3, 1'b0, 1'b0);

    // Boundary=0 never starts a drain; accumulation still lands, so FSM stayed idle
    bus.Conv_size_output_Boundary   = '0;
    bus.drain_Accumulator_buffer_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("s6 zero_valid", 64'(bus.buffer_PPU_data.valid), 64'd0);
      check("s6 zero_addr", 64'(bus.buffer_PPU_data.addr), 64'd2);
    end
    drive(0, 1, 1);
    tick;
    clear_xbar;
    bus.drain_Accumulator_buffer_en = 1'b0;
    tick;
    exp_mem[0][1] = 24'd1;
    // Boundary above DEPTH clamps to DEPTH
    run_drain("s6c", 100, 64, 1'b0, 1'b0);

    // reset in the middle of a drain
    drive(0, 2, 11);
    drive(2, 3, 4);
    tick;
    clear_xbar;
    bus.Conv_size_output_Boundary   = 7'd4;
    bus.drain_Accumulator_buffer_en = 1'b1;
    tick;
    bus.drain_Accumulator_buffer_en = 1'b0;
    tick;
    check("s7 first_valid", 64'(bus.buffer_PPU_data.valid), 64'd1);
    check("s7 first_addr", 64'(bus.buffer_PPU_data.addr), 64'd0);
    rst = 1'b1;
    tick;
    check("s7 rst_valid", 64'(bus.buffer_PPU_data.valid), 64'd0);
    check("s7 rst_addr", 64'(bus.buffer_PPU_data.addr), 64'd0);
    check("s7 rst_last", 64'(bus.buffer_PPU_data.last), 64'd0);
    for (int b = 0; b < int'(DefNumBanks); b++) begin
      check("s7 rst_data", 64'(bus.buffer_PPU_data.data[b]), 64'd0);
    end
    rst = 1'b0;
    tick;
    tick;
    check("s7 stays_idle", 64'(bus.buffer_PPU_data.valid), 64'd0);
    run_drain("s7", 4, 4, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_accumulator_buffer_core.md
PE_ACCUMULATOR_BUFFER_CORE -- requirements
Module: pe_accumulator_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, the number of crossbar output banks.
REQ-002 SHALL have parameter DATA_W, default 16, the signed product width per bank input.
REQ-003 SHALL have parameter ACC_W, default 24, the signed accumulator entry width.
REQ-004 SHALL have parameter DEPTH, default 64, the entries per bank; AW = clog2(DEPTH).
REQ-005 SHALL have clk, input, 1, the clock; all logic is rising-edge.
REQ-006 SHALL have rst, input, 1, the reset: synchronous, active-high.
REQ-007 SHALL have Conv_size_output_Boundary, input, AW+1, the number of addresses to drain.
REQ-008 SHALL have drain_Accumulator_buffer_en, input, 1, the drain request (level).
REQ-009 SHALL have crossbar_buffer_data_in, input, crossbar_buffer_in_PACKET, with per bank {valid, addr[AW], data signed DATA_W}.
REQ-010 SHALL have buffer_PPU_data, output, Buffer_PPU_PACKET, carrying {valid, last, addr[AW], data[NUM_BANKS] signed ACC_W}.

Function
REQ-011 SHALL hold NUM_BANKS x DEPTH signed ACC_W entries; each bank is independent.
REQ-012 In IDLE, each bank with valid=1 SHALL update entry[bank][addr] to entry + sign-extended data at the next edge.
REQ-013 Accumulations to the same address on back-to-back cycles SHALL all be counted; the read path sees the value written at the previous edge.
REQ-014 The add SHALL wrap in two's complement when PE_ACC_SATURATE_EN is undefined.
REQ-015 The FSM SHALL have states IDLE and DRAIN, plus a one-bit armed flag.
REQ-016 IDLE->DRAIN SHALL occur at an edge where drain_en=1, armed=1 and Boundary!=0; the drain counter c is then set to 0.
REQ-017 Boundary=0 SHALL produce no output and no state change.
REQ-018 A Boundary value greater than DEPTH SHALL be clamped to DEPTH.
REQ-019 The Boundary value SHALL be latched on entry to DRAIN; later changes are ignored until the drain ends.
REQ-020 In each DRAIN cycle, the next edge SHALL register valid=1, addr=c and data[b]=entry[b][c] for all b into buffer_PPU_data.
REQ-021 In the same DRAIN cycle, entry[b][c] SHALL be cleared to 0 and c SHALL be incremented.
REQ-022 last SHALL be 1 on the output for c = Boundary-1; that edge returns the FSM to IDLE and clears armed.
REQ-023 armed SHALL be set when drain_en=0 is sampled, so a held drain_en does not re-trigger.
REQ-024 Output valid SHALL be 0 in every cycle not loaded by a DRAIN cycle; addr, data and last then hold their last values.
REQ-025 Crossbar inputs arriving while in DRAIN SHALL be dropped.
REQ-026 Deasserting drain_en in the middle of a drain SHALL NOT abort the drain.
REQ-027 Drain latency SHALL be: drain_en sampled at edge N gives address 0 on the output after edge N+1.
REQ-028 A full drain SHALL produce Boundary consecutive valid cycles.

Reset
REQ-029 rst SHALL set all entries to 0, the FSM to IDLE, c=0 and armed=1.
REQ-030 rst SHALL set every buffer_PPU_data field to 0.
REQ-031 rst SHALL take priority over everything else, including in the middle of a drain.

Configuration
REQ-032 With PE_ACC_SATURATE_EN defined, the add SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-033 Without PE_ACC_SATURATE_EN, the add SHALL wrap modulo 2^ACC_W.

Structure
REQ-034 crossbar_buffer_in_PACKET, Buffer_PPU_PACKET and the parameter defaults SHALL live in the shared PE package.
REQ-035 The design SHALL use one sub-module, acc_bank: a single bank with an accumulate port and a drain-read-and-clear port, instantiated NUM_BANKS times.

Verification
REQ-036 Scenario: after rst, bank0 addr3 gets +5 then -2, then drain with Boundary=4 -> four valid outputs, addr 0..3; data[0]=3 at addr3, all else 0; last only at addr3.
REQ-037 Scenario: bank1 addr0 gets +100 on 3 consecutive cycles -> the drain shows 300.
REQ-038 Scenario: drain_en held high for 10 cycles with Boundary=2 -> exactly 2 valid outputs, then no re-trigger until drain_en goes low then high.
REQ-039 Scenario: drain twice with no accumulation in between -> the second drain returns all zeros.
REQ-040 Scenario: entry at 8388600 gets +100 -> -8388516 without PE_ACC_SATURATE_EN; 8388607 with it.
REQ-041 Scenario: Boundary=0 with drain_en=1 -> no valid output. Separately, rst asserted at c=1 of a 4-address drain -> valid=0 and all entries 0.
